// File: rtl/barreira_pkg.sv
// rtl/barreira_pkg.sv - shared state type and output encodings for the barrier timer
package barreira_pkg;

  localparam int LARGURA = 7;

  typedef enum logic [1:0] {
    REPOUSO  = 2'd0,
    CONTANDO = 2'd1,
    ESPERA   = 2'd2
  } estado_t;

  // Idle encoding: Tempo > Terminar keeps the downstream comparator false (barrier closed)
  localparam logic [LARGURA-1:0] TEMPO_REPOUSO    = 7'd127;
  localparam logic [LARGURA-1:0] TERMINAR_REPOUSO = 7'd0;

endpackage

// File: rtl/temporizador_barreira_if.sv
// rtl/temporizador_barreira_if.sv - request/sensor inputs and timer output bus
interface temporizador_barreira_if;
  import barreira_pkg::*;

  logic               pedido;
  logic               sensor;
  logic [LARGURA-1:0] Tempo;
  logic [LARGURA-1:0] Terminar;
  logic               ativo;
  logic               fim;

  modport master (
    output pedido, sensor,
    input  Tempo, Terminar, ativo, fim
  );

  modport slave (
    input  pedido, sensor,
    output Tempo, Terminar, ativo, fim
  );

endinterface

// File: rtl/divisor_segundo.sv
// rtl/divisor_segundo.sv - one-second prescaler producing a single-cycle tick
module divisor_segundo #(
  parameter int TICKS_POR_SEG = 50_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic limpar,
  input  logic habilitar,
  output logic tick
);

  localparam int CW = (TICKS_POR_SEG > 1) ? $clog2(TICKS_POR_SEG) : 1;
  localparam logic [CW-1:0] ULTIMO = CW'(TICKS_POR_SEG - 1);

  if (TICKS_POR_SEG < 2) begin : g_ticks_invalido
    $error("divisor_segundo: TICKS_POR_SEG must be at least 2");
  end

  logic [CW-1:0] contagem;

  // Free-running 0..TICKS_POR_SEG-1 count while enabled; clear wins over counting
  always_ff @(posedge clk) begin
    if (reset || limpar) begin
      contagem <= '0;
    end else if (habilitar) begin
      if (contagem == ULTIMO) begin
        contagem <= '0;
      end else begin
        contagem <= contagem + 1'b1;
      end
    end
  end

  assign tick = habilitar && (contagem == ULTIMO);

endmodule

// File: rtl/temporizador_barreira.sv
// rtl/temporizador_barreira.sv - seconds timer and sequencer feeding the barrier-close comparator
module temporizador_barreira
  import barreira_pkg::*;
#(
  parameter int TICKS_POR_SEG = 50_000_000,
  parameter int DURACAO       = 6
) (
  input logic                    clk,
  input logic                    reset,
  temporizador_barreira_if.slave bus
);

  if (DURACAO < 1 || DURACAO > 126) begin : g_duracao_invalida
    $error("temporizador_barreira: DURACAO must be within 1..126");
  end

  localparam logic [LARGURA-1:0] TERMINAR_ATIVO = LARGURA'(DURACAO);

  estado_t            estado;
  logic [LARGURA-1:0] tempo_q;
  logic [LARGURA-1:0] terminar_q;
  logic               ativo_q;
  logic               fim_q;
  logic               tick;
  logic               limpar;
  logic               habilitar;

  // Prescaler runs only while a cycle is in progress and restarts on every request
  assign habilitar = (estado != REPOUSO);
  assign limpar    = bus.pedido || (estado == REPOUSO);

  divisor_segundo #(
    .TICKS_POR_SEG(TICKS_POR_SEG)
  ) u_divisor (
    .clk      (clk),
    .reset    (reset),
    .limpar   (limpar),
    .habilitar(habilitar),
    .tick     (tick)
  );

  // Sequencer: request beats expiry/sensor, which beats the per-second increment
  always_ff @(posedge clk) begin
    if (reset) begin
      estado     <= REPOUSO;
      tempo_q    <= TEMPO_REPOUSO;
      terminar_q <= TERMINAR_REPOUSO;
      ativo_q    <= 1'b0;
      fim_q      <= 1'b0;
    end else begin
      fim_q <= 1'b0;
      if (bus.pedido) begin
        estado     <= CONTANDO;
        tempo_q    <= '0;
        terminar_q <= TERMINAR_ATIVO;
        ativo_q    <= 1'b1;
      end else begin
        unique case (estado)
          CONTANDO: begin
            if (tick) begin
              if (tempo_q < terminar_q) begin
                tempo_q <= tempo_q + 1'b1;
              end else if (bus.sensor) begin
                // Vehicle still under the barrier: hold Tempo at the deadline
                estado <= ESPERA;
              end else begin
                estado     <= REPOUSO;
                tempo_q    <= TEMPO_REPOUSO;
                terminar_q <= TERMINAR_REPOUSO;
                ativo_q    <= 1'b0;
                fim_q      <= 1'b1;
              end
            end
          end
          ESPERA: begin
            if (!bus.sensor) begin
              estado     <= REPOUSO;
              tempo_q    <= TEMPO_REPOUSO;
              terminar_q <= TERMINAR_REPOUSO;
              ativo_q    <= 1'b0;
              fim_q      <= 1'b1;
            end
          end
          default: begin
            tempo_q    <= TEMPO_REPOUSO;
            terminar_q <= TERMINAR_REPOUSO;
            ativo_q    <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.Tempo    = tempo_q;
  assign bus.Terminar = terminar_q;
  assign bus.ativo    = ativo_q;
  assign bus.fim      = fim_q;

endmodule

// File: tb/tb_temporizador_barreira.sv
// tb/tb_temporizador_barreira.sv - table-driven and randomized checks of temporizador_barreira
module tb_temporizador_barreira;

  localparam int T = 4;
  localparam int D = 6;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  temporizador_barreira_if bus ();

  temporizador_barreira #(
    .TICKS_POR_SEG(T),
    .DURACAO      (D)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit rst;
    bit ped;
    bit sen;
    int n;
    int tempo;
    int terminar;
    int ativo;
    int fim;
  } vec_t;

  vec_t tab[$];

  task automatic chk(input string nome, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      if (errors < 40)
        $display("FAIL %s: got %0d expected %0d at %0t", nome, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input int te, input int tr, input int at, input int fm);
    chk({tag, " Tempo"}, int'(bus.Tempo), te);
    chk({tag, " Terminar"}, int'(bus.Terminar), tr);
    chk({tag, " ativo"}, int'(bus.ativo), at);
    chk({tag, " fim"}, int'(bus.fim), fm);
  endtask

  // One clock edge with the given inputs; outputs are examined 1 time unit after the edge
  task automatic edge_once(input bit r, input bit p, input bit s);
    reset      = r;
    bus.pedido = p;
    bus.sensor = s;
    @(posedge clk);
    #1;
  endtask

  // Behavioural reference: elapsed cycles since acceptance, Tempo = cycles / T
  bit m_active, m_wait, m_fim;
  int m_cyc;

  task automatic model_step(input bit r, input bit p, input bit s);
    m_fim = 1'b0;
    if (r) begin
      m_active = 1'b0; m_wait = 1'b0; m_cyc = 0;
    end else if (p) begin
      m_active = 1'b1; m_wait = 1'b0; m_cyc = 0;
    end else if (m_active && !m_wait) begin
      m_cyc++;
      if (m_cyc == (D + 1) * T) begin
        if (s) m_wait = 1'b1;
        else begin m_active = 1'b0; m_fim = 1'b1; end
      end
    end else if (m_wait && !s) begin
      m_active = 1'b0; m_wait = 1'b0; m_fim = 1'b1;
    end
  endtask

  function automatic int m_tempo();
    if (!m_active) return 127;
    if (m_wait) return D;
    return m_cyc / T;
  endfunction

  initial begin
    reset = 1'b1;
    bus.pedido = 1'b0;
    bus.sensor = 1'b0;

    //          rst ped sen  n  Tempo Term ativo fim
    tab.push_back('{1, 0, 0,  2, 127, 0, 0, 0});  // reset
    tab.push_back('{0, 1, 0,  1,   0, 6, 1, 0});  // basic: accept
    tab.push_back('{0, 0, 0,  4,   1, 6, 1, 0});
    tab.push_back('{0, 0, 0,  4,   2, 6, 1, 0});
    tab.push_back('{0, 0, 0,  4,   3, 6, 1, 0});
    tab.push_back('{0, 0, 0,  4,   4, 6, 1, 0});
    tab.push_back('{0, 0, 0,  4,   5, 6, 1, 0});
    tab.push_back('{0, 0, 0,  4,   6, 6, 1, 0});
    tab.push_back('{0, 0, 0,  3,   6, 6, 1, 0});  // one cycle before expiry
    tab.push_back('{0, 0, 0,  1, 127, 0, 0, 1});  // expiry at 28 cycles
    tab.push_back('{0, 0, 0,  1, 127, 0, 0, 0});  // fim lasts one cycle
    tab.push_back('{0, 1, 0,  1,   0, 6, 1, 0});  // retrigger: first request
    tab.push_back('{0, 0, 0, 16,   4, 6, 1, 0});
    tab.push_back('{0, 1, 0,  1,   0, 6, 1, 0});  // second request at Tempo=4
    tab.push_back('{0, 0, 0, 27,   6, 6, 1, 0});
    tab.push_back('{0, 0, 0,  1, 127, 0, 0, 1});  // 28 cycles after second request
    tab.push_back('{0, 1, 0,  1,   0, 6, 1, 0});  // vehicle held
    tab.push_back('{0, 0, 1, 28,   6, 6, 1, 0});  // expiry tick with sensor -> ESPERA
    tab.push_back('{0, 0, 1, 10,   6, 6, 1, 0});
    tab.push_back('{0, 0, 0,  1, 127, 0, 0, 1});  // sensor drop
    tab.push_back('{0, 0, 0,  1, 127, 0, 0, 0});
    tab.push_back('{0, 1, 0, 28,   6, 6, 1, 0});  // simultaneous: up to expiry tick
    tab.push_back('{0, 1, 0,  1,   0, 6, 1, 0});  // pedido on expiry tick
    tab.push_back('{0, 0, 0,  4,   1, 6, 1, 0});  // prescaler restarted
    tab.push_back('{0, 0, 0,  8,   3, 6, 1, 0});
    tab.push_back('{1, 0, 0,  1, 127, 0, 0, 0});  // reset mid-count, no fim
    tab.push_back('{0, 0, 1, 30, 127, 0, 0, 0});  // stays idle, sensor ignored

    foreach (tab[i]) begin
      for (int k = 0; k < tab[i].n; k++)
        edge_once(tab[i].rst, (k == 0) ? tab[i].ped : 1'b0, tab[i].sen);
      chk_all($sformatf("vec%0d", i), tab[i].tempo, tab[i].terminar, tab[i].ativo, tab[i].fim);
    end

    // Hand sequence: fim never appears in the cycles following a mid-count reset
    edge_once(1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 12; k++) edge_once(1'b0, 1'b0, 1'b0);
    edge_once(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      chk("post_reset fim", int'(bus.fim), 0);
      edge_once(1'b0, 1'b0, 1'b0);
    end

    // Randomized stimulus against the reference model
    edge_once(1'b1, 1'b0, 1'b0);
    model_step(1'b1, 1'b0, 1'b0);
    begin
      bit r, p, s;
      s = 1'b0;
      for (int c = 0; c < 4000; c++) begin
        r = ($urandom_range(0, 599) == 0);
        p = ($urandom_range(0, 44) == 0);
        if ($urandom_range(0, 9) == 0) s = ~s;
        model_step(r, p, s);
        edge_once(r, p, s);
        chk_all("rand", m_tempo(), m_active ? D : 0, int'(m_active), int'(m_fim));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
